// File: rtl/flash_ctrl.sv
// NAND flash bus controller: executes one bus mode per instruction with fixed
// 2-clock strobe cycles, handshaking bytes with show-ahead core FIFOs.
module flash_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  core_data_out,
    output logic [7:0]  core_data_in,
    input  logic [31:0] instruction,
    input  logic        c_data_in_rdy,
    input  logic        c_data_out_rdy,
    input  logic        iq_empty,
    output logic        ack_mode_read,
    output logic        req_core_data,
    output logic        output_dval,
    output logic        data_oe,
    output logic        oCE_N,
    output logic        oCLE,
    output logic        oALE,
    output logic        oWE_N,
    output logic        oRE_N,
    output logic        oWP_N,
    input  logic        iRB_N,
    output logic [7:0]  flash_data,
    input  logic [7:0]  flash_q
);

    localparam logic [3:0] MODE_STANDBY  = 4'd0;
    localparam logic [3:0] MODE_CMD      = 4'd2;
    localparam logic [3:0] MODE_ADDR     = 4'd3;
    localparam logic [3:0] MODE_DIN      = 4'd4;
    localparam logic [3:0] MODE_DOUT     = 4'd5;
    localparam logic [3:0] MODE_DOUT_END = 4'd6;
    localparam logic [3:0] MODE_WP       = 4'd7;

    typedef enum logic [1:0] {
        S_RESET_STBY,
        S_WAIT,
        S_PH1,
        S_PH2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_rep;
    logic [3:0]  w_rep_next;

    logic        r_ce_n, r_cle, r_ale, r_we_n, r_re_n, r_wp_n, r_data_oe;
    logic        r_ack, r_req, r_dval;
    logic [7:0]  r_flash_data, r_core_data_in;

    logic        w_ce_n_next, w_cle_next, w_ale_next, w_we_n_next, w_re_n_next;
    logic        w_wp_n_next, w_data_oe_next, w_ack_next, w_req_next, w_dval_next;
    logic [7:0]  w_flash_data_next, w_core_data_in_next;

    logic [3:0]  w_mode;
    logic        w_is_wr, w_is_rd, w_start_ok, w_launch;
    logic        w_unused_instr;

    assign w_mode         = instruction[3:0];
    assign w_unused_instr = ^instruction[31:8];
    assign w_is_wr        = (w_mode == MODE_CMD) || (w_mode == MODE_ADDR) || (w_mode == MODE_DIN);
    assign w_is_rd        = (w_mode == MODE_DOUT) || (w_mode == MODE_DOUT_END);

    // Gate evaluated before every PH1, including each repetition of one instruction.
    assign w_start_ok = !iq_empty
                     && (!w_is_wr || c_data_in_rdy)
                     && (!w_is_rd || (c_data_out_rdy && iRB_N))
                     && (!((w_mode == MODE_ADDR) || (w_mode == MODE_DIN)) || iRB_N);

    always_comb begin
        w_state_next        = r_state;
        w_rep_next          = r_rep;
        w_ce_n_next         = 1'b0;
        w_cle_next          = 1'b0;
        w_ale_next          = 1'b0;
        w_we_n_next         = 1'b1;
        w_re_n_next         = 1'b1;
        w_wp_n_next         = 1'b1;
        w_data_oe_next      = 1'b0;
        w_flash_data_next   = r_flash_data;
        w_core_data_in_next = r_core_data_in;
        w_ack_next          = 1'b0;
        w_req_next          = 1'b0;
        w_dval_next         = 1'b0;
        w_launch            = 1'b0;

        case (r_state)
            S_RESET_STBY: w_state_next = S_WAIT;
            S_WAIT:       w_launch = w_start_ok;
            S_PH1: begin
                w_state_next   = S_PH2;
                w_ce_n_next    = (w_mode == MODE_STANDBY) || (w_mode == MODE_DOUT_END);
                w_cle_next     = (w_mode == MODE_CMD);
                w_ale_next     = (w_mode == MODE_ADDR);
                w_wp_n_next    = (w_mode != MODE_WP);
                w_data_oe_next = w_is_wr;
                w_ack_next     = (r_rep == instruction[7:4]);
                w_req_next     = w_is_wr;
                w_dval_next    = w_is_rd;
                if (w_is_rd) begin
                    w_core_data_in_next = flash_q;
                end
            end
            S_PH2: begin
                // r_ack marks the final repetition that just completed.
                w_rep_next = r_ack ? 4'd0 : r_rep + 4'd1;
                w_launch   = w_start_ok;
            end
            default: w_state_next = S_RESET_STBY;
        endcase

        if (w_launch) begin
            w_state_next   = S_PH1;
            w_ce_n_next    = (w_mode == MODE_STANDBY);
            w_cle_next     = (w_mode == MODE_CMD);
            w_ale_next     = (w_mode == MODE_ADDR);
            w_we_n_next    = !w_is_wr;
            w_re_n_next    = !w_is_rd;
            w_wp_n_next    = (w_mode != MODE_WP);
            w_data_oe_next = w_is_wr;
            if (w_is_wr) begin
                w_flash_data_next = core_data_out;
            end
        end else if ((r_state == S_WAIT) || (r_state == S_PH2)) begin
            w_state_next = S_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RESET_STBY;
            r_rep          <= 4'd0;
            r_ce_n         <= 1'b1;
            r_cle          <= 1'b0;
            r_ale          <= 1'b0;
            r_we_n         <= 1'b1;
            r_re_n         <= 1'b1;
            r_wp_n         <= 1'b1;
            r_data_oe      <= 1'b0;
            r_flash_data   <= 8'd0;
            r_core_data_in <= 8'd0;
            r_ack          <= 1'b0;
            r_req          <= 1'b0;
            r_dval         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_rep          <= w_rep_next;
            r_ce_n         <= w_ce_n_next;
            r_cle          <= w_cle_next;
            r_ale          <= w_ale_next;
            r_we_n         <= w_we_n_next;
            r_re_n         <= w_re_n_next;
            r_wp_n         <= w_wp_n_next;
            r_data_oe      <= w_data_oe_next;
            r_flash_data   <= w_flash_data_next;
            r_core_data_in <= w_core_data_in_next;
            r_ack          <= w_ack_next;
            r_req          <= w_req_next;
            r_dval         <= w_dval_next;
        end
    end

    assign oCE_N         = r_ce_n;
    assign oCLE          = r_cle;
    assign oALE          = r_ale;
    assign oWE_N         = r_we_n;
    assign oRE_N         = r_re_n;
    assign oWP_N         = r_wp_n;
    assign data_oe       = r_data_oe;
    assign flash_data    = r_flash_data;
    assign core_data_in  = r_core_data_in;
    assign ack_mode_read = r_ack;
    assign req_core_data = r_req;
    assign output_dval   = r_dval;

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed bench for flash_ctrl; acts as the core FIFOs, popping half a clock
// after each registered pulse so the next head is visible at the following edge.
`timescale 1ns/1ps
module tb_flash_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  core_data_out;
    logic [7:0]  core_data_in;
    logic [31:0] instruction;
    logic        c_data_in_rdy, c_data_out_rdy, iq_empty;
    logic        ack_mode_read, req_core_data, output_dval, data_oe;
    logic        oCE_N, oCLE, oALE, oWE_N, oRE_N, oWP_N;
    logic        iRB_N;
    logic [7:0]  flash_data;
    logic [7:0]  flash_q;

    int checks = 0;
    int errors = 0;
    logic [7:0] e_fd  = 8'd0;
    logic [7:0] e_cdi = 8'd0;

    // Bus vector: {CE_N, CLE, ALE, WE_N, RE_N, WP_N, data_oe, ack, req, dval}
    logic [9:0] bus;
    assign bus = {oCE_N, oCLE, oALE, oWE_N, oRE_N, oWP_N, data_oe,
                  ack_mode_read, req_core_data, output_dval};

    localparam logic [9:0] STBY     = 10'b1001110000;
    localparam logic [9:0] IDLE     = 10'b0001110000;
    localparam logic [9:0] M0_P1    = 10'b1001110000;
    localparam logic [9:0] M0_P2    = 10'b1001110100;
    localparam logic [9:0] M1_P2    = 10'b0001110100;
    localparam logic [9:0] M2_P1    = 10'b0100111000;
    localparam logic [9:0] M2_P2    = 10'b0101111110;
    localparam logic [9:0] M2_P2_NA = 10'b0101111010;
    localparam logic [9:0] M3_P1    = 10'b0010111000;
    localparam logic [9:0] M3_P2    = 10'b0011111110;
    localparam logic [9:0] M3_P2_NA = 10'b0011111010;
    localparam logic [9:0] M4_P1    = 10'b0000111000;
    localparam logic [9:0] M4_P2    = 10'b0001111110;
    localparam logic [9:0] RD_P1    = 10'b0001010000;
    localparam logic [9:0] M5_P2    = 10'b0001110101;
    localparam logic [9:0] M5_P2_NA = 10'b0001110001;
    localparam logic [9:0] M6_P2    = 10'b1001110101;
    localparam logic [9:0] M7_P1    = 10'b0001100000;
    localparam logic [9:0] M7_P2    = 10'b0001100100;

    flash_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .core_data_out (core_data_out),
        .core_data_in  (core_data_in),
        .instruction   (instruction),
        .c_data_in_rdy (c_data_in_rdy),
        .c_data_out_rdy(c_data_out_rdy),
        .iq_empty      (iq_empty),
        .ack_mode_read (ack_mode_read),
        .req_core_data (req_core_data),
        .output_dval   (output_dval),
        .data_oe       (data_oe),
        .oCE_N         (oCE_N),
        .oCLE          (oCLE),
        .oALE          (oALE),
        .oWE_N         (oWE_N),
        .oRE_N         (oRE_N),
        .oWP_N         (oWP_N),
        .iRB_N         (iRB_N),
        .flash_data    (flash_data),
        .flash_q       (flash_q)
    );

    always #6 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [9:0] exp_bus);
        check({tag, ".bus"}, {22'd0, bus}, {22'd0, exp_bus});
        check({tag, ".fd"}, {24'd0, flash_data}, {24'd0, e_fd});
        check({tag, ".cdi"}, {24'd0, core_data_in}, {24'd0, e_cdi});
        $display("step %s bus=%b fd=%h cdi=%h", tag, bus, flash_data, core_data_in);
    endtask

    task automatic step(input string tag, input logic [9:0] exp_bus);
        @(negedge clk);
        check_now(tag, exp_bus);
    endtask

    // One single-repetition instruction: PH1, PH2 (pop), then back to idle.
    task automatic op1(input string tag, input logic [31:0] instr,
                       input logic [9:0] b1, input logic [9:0] b2);
        instruction = instr;
        iq_empty    = 1'b0;
        if (instr[3:0] inside {4'd2, 4'd3, 4'd4}) e_fd = core_data_out;
        step({tag, "_ph1"}, b1);
        if (instr[3:0] inside {4'd5, 4'd6}) e_cdi = flash_q;
        step({tag, "_ph2"}, b2);
        iq_empty = 1'b1;
        step({tag, "_idle"}, IDLE);
    endtask

    initial begin
        rst            = 1'b0;
        instruction    = 32'hffff0000;
        iq_empty       = 1'b1;
        c_data_in_rdy  = 1'b0;
        c_data_out_rdy = 1'b0;
        iRB_N          = 1'b1;
        core_data_out  = 8'h00;
        flash_q        = 8'h00;

        repeat (2) @(negedge clk);
        check_now("reset", STBY);
        @(posedge clk);
        #1 rst = 1'b1;
        step("stby", STBY);
        step("idle0", IDLE);
        step("iqe_1", IDLE);
        step("iqe_2", IDLE);

        op1("m0", 32'hffff0000, M0_P1, M0_P2);
        op1("m1", 32'hffff0001, IDLE, M1_P2);
        op1("m15", 32'hffff000f, IDLE, M1_P2);
        c_data_in_rdy = 1'b1;
        core_data_out = 8'h5a;
        op1("m2", 32'hffff0002, M2_P1, M2_P2);
        core_data_out = 8'ha5;
        op1("m3", 32'hffff0003, M3_P1, M3_P2);
        core_data_out = 8'h11;
        op1("m4", 32'hffff0004, M4_P1, M4_P2);
        c_data_out_rdy = 1'b1;
        flash_q = 8'h3c;
        op1("m5", 32'hffff0005, RD_P1, M5_P2);
        flash_q = 8'hc3;
        op1("m6", 32'hffff0006, RD_P1, M6_P2);
        op1("m7", 32'hffff0007, M7_P1, M7_P2);

        // Five back-to-back address cycles, one ack at the end.
        instruction   = 32'hffff0043;
        core_data_out = 8'h10;
        iq_empty      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e_fd = core_data_out;
            step($sformatf("rep%0d_ph1", k), M3_P1);
            step($sformatf("rep%0d_ph2", k), (k == 4) ? M3_P2 : M3_P2_NA);
            core_data_out = core_data_out + 8'd1;
            if (k == 4) iq_empty = 1'b1;
        end
        step("rep_idle", IDLE);

        // Write-data stall, with the ready flag dropping mid-operation.
        instruction   = 32'hffff0012;
        core_data_out = 8'h20;
        c_data_in_rdy = 1'b0;
        iq_empty      = 1'b0;
        step("wst_w1", IDLE);
        step("wst_w2", IDLE);
        c_data_in_rdy = 1'b1;
        e_fd = 8'h20;
        step("wst_b0_ph1", M2_P1);
        c_data_in_rdy = 1'b0;
        step("wst_b0_ph2", M2_P2_NA);
        core_data_out = 8'h21;
        step("wst_w3", IDLE);
        step("wst_w4", IDLE);
        c_data_in_rdy = 1'b1;
        e_fd = 8'h21;
        step("wst_b1_ph1", M2_P1);
        step("wst_b1_ph2", M2_P2);
        iq_empty = 1'b1;
        step("wst_idle", IDLE);

        // Read stall: read FIFO full, then flash busy between repetitions.
        instruction    = 32'hffff0015;
        c_data_out_rdy = 1'b0;
        flash_q        = 8'h77;
        iq_empty       = 1'b0;
        step("rst_w1", IDLE);
        step("rst_w2", IDLE);
        c_data_out_rdy = 1'b1;
        step("rd_b0_ph1", RD_P1);
        e_cdi = 8'h77;
        step("rd_b0_ph2", M5_P2_NA);
        iRB_N   = 1'b0;
        flash_q = 8'h88;
        step("rd_busy1", IDLE);
        step("rd_busy2", IDLE);
        iRB_N = 1'b1;
        step("rd_b1_ph1", RD_P1);
        e_cdi = 8'h88;
        step("rd_b1_ph2", M5_P2);
        iq_empty = 1'b1;
        step("rd_idle", IDLE);

        // Async reset in PH1 of a second repetition; the pending repeat is dropped.
        instruction   = 32'hffff0012;
        core_data_out = 8'h30;
        c_data_in_rdy = 1'b1;
        iq_empty      = 1'b0;
        e_fd = 8'h30;
        step("ar_b0_ph1", M2_P1);
        step("ar_b0_ph2", M2_P2_NA);
        core_data_out = 8'h31;
        e_fd = 8'h31;
        step("ar_b1_ph1", M2_P1);
        #1 rst = 1'b0;
        #1;
        e_fd  = 8'h00;
        e_cdi = 8'h00;
        check_now("ar_async", STBY);
        @(posedge clk);
        #1 rst = 1'b1;
        step("ar_stby", STBY);
        step("ar_idle", IDLE);
        e_fd = 8'h31;
        step("ar_r0_ph1", M2_P1);
        step("ar_r0_ph2", M2_P2_NA);
        core_data_out = 8'h32;
        e_fd = 8'h32;
        step("ar_r1_ph1", M2_P1);
        step("ar_r1_ph2", M2_P2);
        iq_empty = 1'b1;
        step("ar_end", IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
